rsa_keygen_seq: RTL and testbench

//  Sequential, parametrised RSA key generator. Accepts P, Q, E on a valid pulse and returns
//  N=P*Q and D=E^-1 mod phi, where phi=(P-1)(Q-1). D comes from an iterative extended Euclid

---
 rtl/rsa_pkg.sv | 22 ++
 rtl/euclid_step.sv | 27 ++
 rtl/rsa_keygen_seq.sv | 174 +++++++++++++++++
 tb/tb_rsa_keygen_seq.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared types and width helpers for the sequential RSA key generator.
// Parameter-dependent sizes are exposed as functions so each module derives them from its own WIDTH.
package rsa_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        ITER,
        FIX,
        DONE
    } state_e;

    // Width of the signed Bezout coefficients t0/t1.
    function automatic int tw(input int width);
        return 2 * width + 2;
    endfunction

    function automatic int default_max_iter(input int width);
        return 3 * width + 2;
    endfunction

endpackage

// File: rtl/euclid_step.sv
// One extended-Euclid step: quotient and remainder of a/b, plus t_next = t0 - q*t1.
// The caller never presents b == 0 while it uses the results.
module euclid_step #(
    parameter int W2 = 8,
    parameter int TW = 10
) (
    input  logic        [W2-1:0] a,
    input  logic        [W2-1:0] b,
    input  logic signed [TW-1:0] t0,
    input  logic signed [TW-1:0] t1,
    output logic        [W2-1:0] rem,
    output logic signed [TW-1:0] t_next
);

    logic        [W2-1:0] quot;
    logic signed [TW-1:0] quot_ext;

    // The low TW bits of the full-width product equal the TW-wide product,
    // so truncating before multiplying gives the same t_next.
    always_comb begin
        quot     = a / b;
        rem      = a % b;
        quot_ext = {{(TW - W2){1'b0}}, quot};
        t_next   = t0 - quot_ext * t1;
    end

endmodule

// File: rtl/rsa_keygen_seq.sv
// Sequential RSA key generator: N = P*Q and D = E^-1 mod (P-1)(Q-1),
// using one extended-Euclid step per clock behind a busy/valid handshake.
module rsa_keygen_seq
    import rsa_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MAX_ITER = default_max_iter(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_p,
    input  logic [WIDTH-1:0]     in_q,
    input  logic [2*WIDTH-1:0]   in_e,
    output logic                 busy,
    output logic                 out_valid,
    output logic [2*WIDTH-1:0]   out_n,
    output logic [2*WIDTH-1:0]   out_d,
    output logic                 err
);

    localparam int W2 = 2 * WIDTH;
    localparam int TW = tw(WIDTH);
    localparam int IW = $clog2(MAX_ITER + 1);

    state_e                state_q, state_d;
    logic [WIDTH-1:0]      p_q, p_d, qp_q, qp_d;
    logic [W2-1:0]         e_q, e_d, n_q, n_d, phi_q, phi_d;
    logic [W2-1:0]         r0_q, r0_d, r1_q, r1_d;
    logic signed [TW-1:0]  t0_q, t0_d, t1_q, t1_d;
    logic [IW-1:0]         it_q, it_d;
    logic                  busy_q, busy_d, out_valid_q, out_valid_d, err_q, err_d;
    logic [W2-1:0]         out_n_q, out_n_d, out_d_q, out_d_d;

    logic [W2-1:0]         n_c, phi_c, rem;
    logic signed [TW-1:0]  t_next;

    euclid_step #(.W2(W2), .TW(TW)) u_step (
        .a      (r0_q),
        .b      (r1_q),
        .t0     (t0_q),
        .t1     (t1_q),
        .rem    (rem),
        .t_next (t_next)
    );

    // NOTE: every signal gets its default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        p_d         = p_q;
        qp_d        = qp_q;
        e_d         = e_q;
        n_d         = n_q;
        phi_d       = phi_q;
        r0_d        = r0_q;
        r1_d        = r1_q;
        t0_d        = t0_q;
        t1_d        = t1_q;
        it_d        = it_q;
        out_valid_d = 1'b0;
        out_n_d     = '0;
        out_d_d     = '0;
        err_d       = 1'b0;

        n_c   = {{WIDTH{1'b0}}, p_q} * {{WIDTH{1'b0}}, qp_q};
        phi_c = ({{WIDTH{1'b0}}, p_q} - W2'(1)) * ({{WIDTH{1'b0}}, qp_q} - W2'(1));

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    p_d     = in_p;
                    qp_d    = in_q;
                    e_d     = in_e;
                    state_d = INIT;
                end
            end
            INIT: begin
                n_d   = n_c;
                phi_d = phi_c;
                r0_d  = phi_c;
                r1_d  = e_q;
                t0_d  = '0;
                t1_d  = TW'(1);
                it_d  = '0;
                if (p_q < WIDTH'(2) || qp_q < WIDTH'(2)) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    out_n_d     = n_c;
                    err_d       = 1'b1;
                end else if (e_q == '0) begin
                    state_d = FIX;
                end else begin
                    state_d = ITER;
                end
            end
            ITER: begin
                if (it_q == IW'(MAX_ITER)) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    out_n_d     = n_q;
                    err_d       = 1'b1;
                end else begin
                    r0_d = r1_q;
                    r1_d = rem;
                    t0_d = t1_q;
                    t1_d = t_next;
                    it_d = it_q + IW'(1);
                    // Leave as soon as the new remainder is zero so FIX follows the last step directly.
                    if (rem == '0) state_d = FIX;
                end
            end
            FIX: begin
                state_d     = DONE;
                out_valid_d = 1'b1;
                out_n_d     = n_q;
                if (r0_q != W2'(1)) begin
                    err_d = 1'b1;
                end else begin
                    out_d_d = t0_q[W2-1:0] + (t0_q[TW-1] ? phi_q : '0);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == INIT) || (state_d == ITER) || (state_d == FIX);
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            p_q         <= '0;
            qp_q        <= '0;
            e_q         <= '0;
            n_q         <= '0;
            phi_q       <= '0;
            r0_q        <= '0;
            r1_q        <= '0;
            t0_q        <= '0;
            t1_q        <= '0;
            it_q        <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_n_q     <= '0;
            out_d_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            p_q         <= p_d;
            qp_q        <= qp_d;
            e_q         <= e_d;
            n_q         <= n_d;
            phi_q       <= phi_d;
            r0_q        <= r0_d;
            r1_q        <= r1_d;
            t0_q        <= t0_d;
            t1_q        <= t1_d;
            it_q        <= it_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_n_q     <= out_n_d;
            out_d_q     <= out_d_d;
            err_q       <= err_d;
        end
    end

    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_n     = out_n_q;
    assign out_d     = out_d_q;
    assign err       = err_q;

endmodule

// File: tb/tb_rsa_keygen_seq.sv
// Directed bench for rsa_keygen_seq: one WIDTH=3 and one WIDTH=4 instance, hand-computed vectors.
module tb_rsa_keygen_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       iv3, busy3, ov3, err3;
    logic [2:0] p3, q3;
    logic [5:0] e3, n3, d3;
    logic       iv4, busy4, ov4, err4;
    logic [3:0] p4, q4;
    logic [7:0] e4, n4, d4;

    int checks   = 0;
    int failures = 0;

    rsa_keygen_seq #(.WIDTH(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(iv3), .in_p(p3), .in_q(q3), .in_e(e3),
        .busy(busy3), .out_valid(ov3), .out_n(n3), .out_d(d3), .err(err3)
    );

    rsa_keygen_seq #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_p(p4), .in_q(q4), .in_e(e4),
        .busy(busy4), .out_valid(ov4), .out_n(n4), .out_d(d4), .err(err4)
    );

    task automatic drive(input int w, input logic v, input int p, input int q, input int e);
        if (w == 3) begin
            iv3 = v; p3 = 3'(p); q3 = 3'(q); e3 = 6'(e);
        end else begin
            iv4 = v; p4 = 4'(p); q4 = 4'(q); e4 = 8'(e);
        end
    endtask

    // Entered at a falling edge; returns at the falling edge after the accepting rising edge.
    task automatic request(input int w, input int p, input int q, input int e);
        drive(w, 1'b1, p, q, e);
        @(negedge clk);
        drive(w, 1'b0, 0, 0, 0);
    endtask

    task automatic sample(input int w, output logic ov, output logic bz, output logic er,
                          output logic [7:0] n, output logic [7:0] d);
        if (w == 3) begin
            ov = ov3; bz = busy3; er = err3; n = {2'b00, n3}; d = {2'b00, d3};
        end else begin
            ov = ov4; bz = busy4; er = err4; n = n4; d = d4;
        end
    endtask

    // lat counts cycles after the request cycle; -1 means out_valid never came.
    task automatic wait_result(input int w, input int start, output int lat,
                               output logic [7:0] n, output logic [7:0] d, output logic er);
        logic ov, bz;
        lat = -1;
        for (int i = start; i < start + 40; i++) begin
            sample(w, ov, bz, er, n, d);
            if (ov) begin
                lat = i;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic ov, bz, er;
        logic [7:0] n, d;
        rst = 1'b1;
        drive(3, 1'b0, 0, 0, 0);
        drive(4, 1'b0, 0, 0, 0);
        repeat (2) @(negedge clk);
        for (int w = 3; w <= 4; w++) begin
            sample(w, ov, bz, er, n, d);
            checks++;
            if ({ov, bz, er} !== 3'b000 || n !== 8'd0 || d !== 8'd0) begin
                failures++;
                $display("FAIL reset_w%0d: got ov=%b busy=%b err=%b n=%0d d=%0d expected all 0", w, ov, bz, er, n, d);
            end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic ov, bz, er;
        logic [7:0] n, d;
        int lat;
        request(3, 3, 5, 3);
        sample(3, ov, bz, er, n, d);
        checks++;
        if (bz !== 1'b1) begin failures++; $display("FAIL basic_busy: got %b expected 1", bz); end
        wait_result(3, 1, lat, n, d, er);
        checks++;
        if (lat !== 6) begin failures++; $display("FAIL basic_latency: got %0d expected 6", lat); end
        checks++;
        if (n !== 8'd15 || d !== 8'd3 || er !== 1'b0) begin
            failures++; $display("FAIL basic_result: got n=%0d d=%0d err=%b expected n=15 d=3 err=0", n, d, er);
        end
        sample(3, ov, bz, er, n, d);
        checks++;
        if (bz !== 1'b0) begin failures++; $display("FAIL basic_busy_drop: got %b expected 0", bz); end
        @(negedge clk);
        sample(3, ov, bz, er, n, d);
        checks++;
        if (ov !== 1'b0 || n !== 8'd0 || d !== 8'd0 || er !== 1'b0) begin
            failures++; $display("FAIL basic_hold_zero: got ov=%b n=%0d d=%0d err=%b expected all 0", ov, n, d, er);
        end
    endtask

    task automatic test_multi();
        logic er;
        logic [7:0] n, d;
        int lat;
        request(3, 5, 7, 5);
        wait_result(3, 1, lat, n, d, er);
        checks++;
        if (lat !== 6 || n !== 8'd35 || d !== 8'd5 || er !== 1'b0) begin
            failures++; $display("FAIL multi_e5: got lat=%0d n=%0d d=%0d err=%b expected lat=6 n=35 d=5 err=0", lat, n, d, er);
        end
        @(negedge clk);
        request(3, 5, 7, 11);
        wait_result(3, 1, lat, n, d, er);
        checks++;
        if (lat !== 6 || n !== 8'd35 || d !== 8'd11 || er !== 1'b0) begin
            failures++; $display("FAIL multi_e11: got lat=%0d n=%0d d=%0d err=%b expected lat=6 n=35 d=11 err=0", lat, n, d, er);
        end
        @(negedge clk);
    endtask

    task automatic test_latency_w4();
        logic er;
        logic [7:0] n, d;
        int lat;
        // (120,7): q=17 -> (7,1); q=7 -> (1,0); t0=-17, D=103, k=2
        request(4, 13, 11, 7);
        wait_result(4, 1, lat, n, d, er);
        checks++;
        if (lat !== 5) begin failures++; $display("FAIL w4_latency: got %0d expected 5", lat); end
        checks++;
        if (n !== 8'd143 || d !== 8'd103 || er !== 1'b0) begin
            failures++; $display("FAIL w4_result: got n=%0d d=%0d err=%b expected n=143 d=103 err=0", n, d, er);
        end
    endtask

    task automatic test_back_to_back();
        logic er;
        logic [7:0] n, d;
        int lat;
        @(negedge clk);
        request(4, 3, 5, 3);
        wait_result(4, 1, lat, n, d, er);
        checks++;
        if (lat !== 6 || n !== 8'd15 || d !== 8'd3 || er !== 1'b0) begin
            failures++; $display("FAIL b2b_result: got lat=%0d n=%0d d=%0d err=%b expected lat=6 n=15 d=3 err=0", lat, n, d, er);
        end
        @(negedge clk);
    endtask

    task automatic test_errors();
        logic er;
        logic [7:0] n, d;
        int lat;
        request(3, 3, 5, 2);
        wait_result(3, 1, lat, n, d, er);
        checks++;
        if (lat !== 4 || n !== 8'd15 || d !== 8'd0 || er !== 1'b1) begin
            failures++; $display("FAIL err_gcd2: got lat=%0d n=%0d d=%0d err=%b expected lat=4 n=15 d=0 err=1", lat, n, d, er);
        end
        @(negedge clk);
        request(3, 1, 5, 3);
        wait_result(3, 1, lat, n, d, er);
        checks++;
        if (lat !== 2 || n !== 8'd5 || d !== 8'd0 || er !== 1'b1) begin
            failures++; $display("FAIL err_p_lt2: got lat=%0d n=%0d d=%0d err=%b expected lat=2 n=5 d=0 err=1", lat, n, d, er);
        end
        @(negedge clk);
        request(3, 3, 5, 0);
        wait_result(3, 1, lat, n, d, er);
        checks++;
        if (lat !== 3 || d !== 8'd0 || er !== 1'b1) begin
            failures++; $display("FAIL err_e0: got lat=%0d d=%0d err=%b expected lat=3 d=0 err=1", lat, d, er);
        end
        @(negedge clk);
        request(3, 2, 2, 3);
        wait_result(3, 1, lat, n, d, er);
        checks++;
        if (lat !== 5 || n !== 8'd4 || d !== 8'd0 || er !== 1'b0) begin
            failures++; $display("FAIL phi_one: got lat=%0d n=%0d d=%0d err=%b expected lat=5 n=4 d=0 err=0", lat, n, d, er);
        end
        @(negedge clk);
    endtask

    task automatic test_busy_ignore();
        logic ov, bz, er;
        logic [7:0] n, d;
        int lat;
        int stray;
        request(3, 3, 5, 3);
        @(negedge clk);
        drive(3, 1'b1, 5, 7, 5);
        @(negedge clk);
        drive(3, 1'b0, 0, 0, 0);
        wait_result(3, 3, lat, n, d, er);
        checks++;
        if (lat !== 6 || n !== 8'd15 || d !== 8'd3 || er !== 1'b0) begin
            failures++; $display("FAIL busy_ignore: got lat=%0d n=%0d d=%0d err=%b expected lat=6 n=15 d=3 err=0", lat, n, d, er);
        end
        drive(3, 1'b1, 5, 7, 5);
        @(negedge clk);
        drive(3, 1'b0, 0, 0, 0);
        stray = 0;
        repeat (10) begin
            sample(3, ov, bz, er, n, d);
            if (ov || bz) stray++;
            @(negedge clk);
        end
        checks++;
        if (stray !== 0) begin failures++; $display("FAIL valid_ignore: got %0d active cycles expected 0", stray); end
    endtask

    task automatic test_reset_mid();
        logic ov, bz, er;
        logic [7:0] n, d;
        int lat;
        request(4, 13, 11, 7);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        sample(4, ov, bz, er, n, d);
        checks++;
        if ({ov, bz, er} !== 3'b000 || n !== 8'd0 || d !== 8'd0) begin
            failures++; $display("FAIL reset_mid: got ov=%b busy=%b err=%b n=%0d d=%0d expected all 0", ov, bz, er, n, d);
        end
        rst = 1'b0;
        request(4, 13, 11, 7);
        wait_result(4, 1, lat, n, d, er);
        checks++;
        if (lat !== 5 || n !== 8'd143 || d !== 8'd103 || er !== 1'b0) begin
            failures++; $display("FAIL after_reset: got lat=%0d n=%0d d=%0d err=%b expected lat=5 n=143 d=103 err=0", lat, n, d, er);
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        drive(3, 1'b0, 0, 0, 0);
        drive(4, 1'b0, 0, 0, 0);
        @(negedge clk);
        test_reset();
        test_basic();
        test_multi();
        test_latency_w4();
        test_back_to_back();
        test_errors();
        test_busy_ignore();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
